// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through FIFO and serialises each
// word as a UART frame (start bit, DBIT data bits LSB first, stop period).
// Contains its own baud-tick generator producing 16 ticks per bit.
//
// FIFO handshake: the FIFO presents r_data whenever empty=0. This block pops
// by raising rd for exactly one cycle while empty=0. The word is captured at
// the same clk edge that advances the FIFO head, so the block owns the data
// from then on. rd is never raised while empty=1 or while reset is asserted.
module fifo_uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy,
  output logic [1:0]      dbg_state
);

  localparam int BW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST   = BW'(DVSR - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [4:0]    S_BIT_LAST  = 5'd15;
  localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [BW-1:0]     baud_reg;
  logic [4:0]        s_reg, s_next;
  logic [NW-1:0]     n_reg, n_next;
  logic [DBIT-1:0]   b_reg, b_next;
  logic              tx_reg, tx_next;
  logic              pop;
  logic              s_tick;

  // Baud divider: parked at 0 while idle so every frame starts on a fresh
  // tick period; free-runs 0..DVSR-1 during a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_reg <= '0;
    end else if (state_reg == IDLE) begin
      baud_reg <= '0;
    end else if (baud_reg == BAUD_LAST) begin
      baud_reg <= '0;
    end else begin
      baud_reg <= baud_reg + 1'b1;
    end
  end

  assign s_tick = (state_reg != IDLE) && (baud_reg == BAUD_LAST);

  // FSM and datapath registers; tx is registered so the pin is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic; tx_next is derived from the state being entered so
  // the registered line changes on the same edge as the state.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          b_next     = r_data;
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP_LAST) begin
            state_next = IDLE;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // Pop is suppressed while reset is held so the FIFO never loses a word
  // that the block cannot capture.
  assign rd        = pop && reset;
  assign tx        = tx_reg;
  assign tx_busy   = (state_reg != IDLE);
  assign dbg_state = state_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives two fifo_uart_tx instances (SB_TICK=16 and 32,
// DVSR=4) from small FIFO models; checks every cycle against a frame-timeline
// model and decodes the serial line with a reference receiver.
module tb_fifo_uart_tx;

  localparam int DVSR    = 4;
  localparam int DBIT    = 8;
  localparam int BIT_CYC = 16 * DVSR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- FIFO models and DUT wiring ----------------
  logic [1:0] empty_w, rd_w, tx_w, busy_w;
  logic [7:0] r_data0, r_data1;
  logic [1:0] dbg0, dbg1;
  logic [7:0] mem [2][32];
  int         wr_ptr [2];
  int         rd_ptr [2];
  int         pop_cnt [2];

  assign empty_w[0] = (rd_ptr[0] == wr_ptr[0]);
  assign empty_w[1] = (rd_ptr[1] == wr_ptr[1]);
  assign r_data0    = mem[0][rd_ptr[0][4:0]];
  assign r_data1    = mem[1][rd_ptr[1][4:0]];

  // FIFO head advances on the edge after a cycle in which rd was seen high.
  always @(posedge clk) begin
    rd_ptr[0] <= pop_cnt[0];
    rd_ptr[1] <= pop_cnt[1];
  end

  fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(16), .DVSR(DVSR)) dut (
    .clk       (clk),
    .reset     (reset),
    .empty     (empty_w[0]),
    .r_data    (r_data0),
    .rd        (rd_w[0]),
    .tx        (tx_w[0]),
    .tx_busy   (busy_w[0]),
    .dbg_state (dbg0)
  );

  fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(32), .DVSR(DVSR)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .empty     (empty_w[1]),
    .r_data    (r_data1),
    .rd        (rd_w[1]),
    .tx        (tx_w[1]),
    .tx_busy   (busy_w[1]),
    .dbg_state (dbg1)
  );

  // ---------------- model, stats, scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  bit         m_active [2];
  int         m_start  [2];
  int         m_len    [2];
  logic [7:0] m_data   [2];
  int         busy_cnt [2];
  int         low_cnt  [2];
  int         hi_cnt   [2];
  int         rd_cnt   [2];
  int         rd_times[$];
  logic       line_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Line level k cycles into a frame: start bit, then data LSB first, then high.
  function automatic logic exp_line(input int k, input logic [7:0] d);
    int idx;
    idx = k / BIT_CYC;
    if (idx == 0) return 1'b0;
    if (idx <= DBIT) return d[idx-1];
    return 1'b1;
  endfunction

  // Per-cycle comparison of both instances against the timeline model.
  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic e_tx, e_busy, e_rd;
      if (!reset) begin
        m_active[i] = 1'b0;
        e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0;
      end else begin
        if (m_active[i] && (cyc - m_start[i]) >= m_len[i]) m_active[i] = 1'b0;
        e_busy = m_active[i];
        e_rd   = !m_active[i] && (rd_ptr[i] != wr_ptr[i]);
        e_tx   = m_active[i] ? exp_line(cyc - m_start[i], m_data[i]) : 1'b1;
        if (e_rd) begin
          m_active[i] = 1'b1;
          m_start[i]  = cyc + 1;
          m_data[i]   = mem[i][rd_ptr[i][4:0]];
        end
      end
      check($sformatf("tx[%0d]", i), tx_w[i], e_tx);
      check($sformatf("tx_busy[%0d]", i), busy_w[i], e_busy);
      check($sformatf("rd[%0d]", i), rd_w[i], e_rd);
      if (busy_w[i] === 1'b1) begin
        busy_cnt[i]++;
        if (tx_w[i] === 1'b0) low_cnt[i]++;
        if (tx_w[i] === 1'b1) hi_cnt[i]++;
      end
      if (rd_w[i] === 1'b1) begin
        rd_cnt[i]++;
        pop_cnt[i]++;
        if (i == 0) rd_times.push_back(cyc);
      end
    end
    line_q.push_back(tx_w[0]);
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push(input int i, input logic [7:0] v);
    mem[i][wr_ptr[i][4:0]] = v;
    wr_ptr[i]++;
    if (i == 0) exp_q.push_back({1'b0, v});
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; low_cnt[i] = 0; hi_cnt[i] = 0; rd_cnt[i] = 0;
    end
    rd_times.delete();
    line_q.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  // Reference receiver: finds a falling edge, samples mid-bit; bit 8 of each
  // result flags a bad start or stop bit.
  task automatic decode();
    int j;
    j = 0;
    got_q.delete();
    while (j + 9 * BIT_CYC + BIT_CYC / 2 < line_q.size()) begin
      if (line_q[j] === 1'b0) begin
        logic [7:0] d;
        logic       bad;
        bad = (line_q[j + BIT_CYC / 2] !== 1'b0);
        for (int b = 0; b < DBIT; b++) d[b] = line_q[j + BIT_CYC * (b + 1) + BIT_CYC / 2];
        if (line_q[j + 9 * BIT_CYC + BIT_CYC / 2] !== 1'b1) bad = 1'b1;
        got_q.push_back({bad, d});
        j = j + 9 * BIT_CYC + BIT_CYC / 2 + 1;
      end else begin
        j++;
      end
    end
  endtask

  task automatic sb_check(input string name);
    int n;
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) check({name, "_word"}, got_q[k], exp_q[k]);
  endtask

  function automatic int count_zeros();
    int z;
    z = 0;
    foreach (line_q[k]) if (line_q[k] !== 1'b1) z++;
    return z;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    m_len[0] = (16 * (1 + DBIT) + 16) * DVSR;
    m_len[1] = (16 * (1 + DBIT) + 32) * DVSR;
    reset = 1'b0;
    run(5);
    reset = 1'b1;

    // Idle with empty FIFO.
    clear_stats();
    run(200);
    check("idle_rd_count", rd_cnt[0], 0);
    check("idle_busy_count", busy_cnt[0], 0);
    check("idle_tx_low", count_zeros(), 0);

    // Single word 0xA5.
    clear_stats();
    push(0, 8'hA5);
    run(700);
    check("a5_rd_count", rd_cnt[0], 1);
    check("a5_busy_cycles", busy_cnt[0], 640);
    check("a5_low_cycles", low_cnt[0], 320);
    decode();
    sb_check("a5");

    // Three preloaded words, back to back.
    clear_stats();
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h55);
    run(2000);
    check("b2b_rd_count", rd_cnt[0], 3);
    check("b2b_rd_times", rd_times.size(), 3);
    if (rd_times.size() >= 3) begin
      check("b2b_gap1", rd_times[1] - rd_times[0], 641);
      check("b2b_gap2", rd_times[2] - rd_times[1], 641);
    end
    check("b2b_empty_after", empty_w[0], 1'b1);
    decode();
    sb_check("b2b");

    // New word arrives while a frame is in flight.
    clear_stats();
    push(0, 8'h96);
    run(200);
    push(0, 8'h3A);
    run(1400);
    check("mid_rd_count", rd_cnt[0], 2);
    if (rd_times.size() >= 2) check("mid_gap", rd_times[1] - rd_times[0], 641);
    decode();
    sb_check("mid");

    // Reset during data bit 3 of 0x3C.
    clear_stats();
    push(0, 8'h3C);
    run(281);
    check("abort_busy_before", busy_w[0], 1'b1);
    reset = 1'b0;
    #1;
    check("abort_tx_async", tx_w[0], 1'b1);
    check("abort_busy_async", busy_w[0], 1'b0);
    check("abort_rd_async", rd_w[0], 1'b0);
    run(3);
    reset = 1'b1;
    clear_stats();
    run(800);
    check("abort_no_rd", rd_cnt[0], 0);
    check("abort_no_busy", busy_cnt[0], 0);
    check("abort_no_tx", count_zeros(), 0);

    // Reset during the start bit: the low line must return high at once.
    clear_stats();
    push(0, 8'hC3);
    run(10);
    check("abort2_tx_before", tx_w[0], 1'b0);
    reset = 1'b0;
    #1;
    check("abort2_tx_async", tx_w[0], 1'b1);
    check("abort2_busy_async", busy_w[0], 1'b0);
    run(2);
    reset = 1'b1;
    clear_stats();
    run(700);
    check("abort2_no_rd", rd_cnt[0], 0);
    check("abort2_no_busy", busy_cnt[0], 0);

    // Two stop bits (SB_TICK=32), word 0x81.
    clear_stats();
    push(1, 8'h81);
    run(760);
    check("sb32_rd_count", rd_cnt[1], 1);
    check("sb32_busy_cycles", busy_cnt[1], 704);
    check("sb32_high_cycles", hi_cnt[1], 256);
    check("sb32_low_cycles", low_cnt[1], 448);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the team's synchronous FIFO: drains words through the FIFO's `rd`/`empty`/`r_data` port and serialises each word as an asynchronous UART frame. The frame is 1 start bit, DBIT data bits sent LSB first, and a stop period. Sits between the transmit FIFO and the chip's serial output pin, with a built-in baud-tick generator, so the FIFO plus this block form a complete buffered UART transmitter.

## Interface
Parameters:
- DBIT, 8, data bits per frame; must equal FIFO word width B.
- SB_TICK, 16, stop-period length in baud ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR, 163, clk cycles per baud tick (16 ticks per bit); minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- empty  input  1  FIFO empty flag.
- r_data  input  DBIT  FIFO head word.
  - Valid whenever empty=0 (first-word fall-through).
  - Advances on the clk edge after a cycle with rd=1.
- rd  output  1  FIFO pop strobe; one-cycle pulse per word.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high while a frame is being transmitted.

## Operation
- Reset (reset=0), applied asynchronously:
  - state=IDLE; tx=1, rd=0, tx_busy=0.
  - Baud counter, tick counter s, bit counter n and shift register all cleared to 0.
- Baud generator:
  - Counter runs 0..DVSR-1; s_tick pulses in the cycle where counter==DVSR-1, then the counter wraps to 0.
  - Counter is held at 0 in IDLE and runs in all other states, so frame timing is exact.
  - Counter width is $clog2(DVSR).
- State IDLE:
  - tx=1, tx_busy=0.
  - If empty=0: assert rd for this cycle only, load r_data into the shift register, clear s, go to START.
  - rd is never asserted while empty=1.
- State START:
  - tx=0.
  - On s_tick: if s==15, clear s and n and go to DATA; otherwise s+1.
- State DATA:
  - tx = shift register bit 0.
  - On s_tick with s==15: clear s and shift right by 1.
    - If n==DBIT-1, go to STOP.
    - Otherwise n+1.
  - On s_tick with s<15: s+1.
- State STOP:
  - tx=1.
  - On s_tick: if s==SB_TICK-1, go to IDLE; otherwise s+1.
- tx_busy is 1 in START, DATA and STOP.
- Counter widths:
  - s is 5 bits, which covers SB_TICK up to 32.
  - n is $clog2(DBIT) bits.
- Captured data is owned by the block after the pop. Later changes on r_data, or further FIFO writes, do not affect the frame in flight.
- Reset during a frame: the frame aborts immediately with tx=1. The popped word is discarded and not re-sent.

## Timing
- Pop: rd is high in the same cycle IDLE samples empty=0 (cycle T).
- tx: falls at the edge ending cycle T, so the line is low from T+1.
- tx_busy: rises with the tx low, i.e. from T+1.
- Bit durations:
  - Start bit: exactly 16*DVSR cycles.
  - Each data bit: exactly 16*DVSR cycles.
  - Stop period: exactly SB_TICK*DVSR cycles.
- Frame length is (16*(1+DBIT)+SB_TICK)*DVSR cycles from T+1. After it, the block is in IDLE with tx=1.
- Back-to-back words: exactly one IDLE cycle (tx=1, the cycle carrying the next rd pulse) separates consecutive frames while empty=0.
- FIFO edge cases:
  - empty falling while the block is busy is ignored until IDLE; no pop occurs mid-frame.
  - The FIFO full/empty boundaries are handled entirely by the FIFO. This block only needs empty=0 before popping.

## Test plan
All scenarios use DVSR=4, DBIT=8, SB_TICK=16 unless stated.
- Reset with empty=1 for 200 cycles -> tx=1, rd=0 and tx_busy=0 throughout; assert reset mid-cycle -> outputs return to reset values without waiting for a clk edge.
- Push 0xA5 -> exactly one rd pulse, then:
  - Line sequence: tx low for 64 cycles, then bits 1,0,1,0,0,1,0,1 for 64 cycles each, then high for 64 cycles.
  - tx_busy is high for exactly 640 cycles.
- Preload 0x00, 0xFF, 0x55 -> exactly 3 rd pulses, 641 cycles apart; a reference UART receiver decodes 0x00, 0xFF, 0x55; empty=1 after the third pop and no further rd.
- Write a new word to the FIFO during a frame, so r_data changes mid-frame -> the current frame bits are unchanged and the new word is sent in the next frame.
- Assert reset during data bit 3 of 0x3C -> tx=1 immediately; after release with empty=1 there is no retransmission and no rd.
- SB_TICK=32, push 0x81 -> stop period is 128 cycles high and total frame is 704 cycles.
